// File: rtl/bm_mod_updown_counter.sv
// bm_mod_updown_counter: modulo-(MAX+1) up/down counter with parallel load,
// variable step size, combinational terminal count and a registered
// one-cycle wrap/limit pulse.
// Optional build macro: BM_COUNTER_SATURATE_EN -- when defined, counting
// past either end saturates at MAX or 0 instead of wrapping. In that build,
// W marks the cycle in which the limit was hit.
module bm_mod_updown_counter #(
  parameter int n   = 4,
  parameter int MAX = 9
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic [n-1:0] R,
  input  logic [n-1:0] S,
  input  logic         L,
  input  logic         E,
  input  logic         up_down,
  output logic [n-1:0] Q,
  output logic         TC,
  output logic         W
);

  // One extra bit of headroom so that Q+S and Q+(MAX+1) never overflow
  // before the modulus test.
  localparam logic [n:0]   MAX_W = (n+1)'(MAX);
  localparam logic [n:0]   MOD_W = (n+1)'(MAX + 1);
  localparam logic [n-1:0] MAX_N = n'(MAX);

  logic [n:0]   q_ext;
  logic [n:0]   r_ext;
  logic [n:0]   s_ext;
  logic [n:0]   seff;
  logic [n:0]   sum;
  logic [n-1:0] q_nx;
  logic         w_nx;

  // Next-state selection: load beats count, count beats hold.
  always_comb begin
    q_ext = {1'b0, Q};
    r_ext = {1'b0, R};
    s_ext = {1'b0, S};
    seff  = (s_ext > MAX_W) ? MAX_W : s_ext;
    sum   = q_ext + seff;
    q_nx  = Q;
    w_nx  = 1'b0;
    if (L) begin
      q_nx = (r_ext > MAX_W) ? MAX_N : R;
    end else if (E) begin
      if (up_down) begin
        if (sum <= MAX_W) begin
          q_nx = n'(sum);
        end else begin
`ifdef BM_COUNTER_SATURATE_EN
          q_nx = MAX_N;
`else
          q_nx = n'(sum - MOD_W);
`endif
          w_nx = 1'b1;
        end
      end else begin
        if (q_ext >= seff) begin
          q_nx = n'(q_ext - seff);
        end else begin
`ifdef BM_COUNTER_SATURATE_EN
          q_nx = '0;
`else
          q_nx = n'(q_ext + MOD_W - seff);
`endif
          w_nx = 1'b1;
        end
      end
    end
  end

  // Count and wrap-pulse registers; reset clears both at once.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Q <= '0;
      W <= 1'b0;
    end else begin
      Q <= q_nx;
      W <= w_nx;
    end
  end

  // Terminal count follows the current direction without waiting for a clock.
  always_comb begin
    TC = up_down ? (Q == MAX_N) : (Q == '0);
  end

endmodule

// File: tb/tb_bm_mod_updown_counter.sv
// Self-checking bench for bm_mod_updown_counter (n=4, MAX=9), covering
// directed scenarios and randomized traffic against an arithmetic
// reference model.
module tb_bm_mod_updown_counter;

  localparam int N  = 4;
  localparam int MX = 9;

  logic         clk;
  logic         rstn;
  logic [N-1:0] r;
  logic [N-1:0] s;
  logic         l;
  logic         e;
  logic         ud;
  logic [N-1:0] q;
  logic         tc;
  logic         w;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int mq = 0;
  bit mw = 0;

  bm_mod_updown_counter #(.n(N), .MAX(MX)) dut (
    .Clock  (clk),
    .Resetn (rstn),
    .R      (r),
    .S      (s),
    .L      (l),
    .E      (e),
    .up_down(ud),
    .Q      (q),
    .TC     (tc),
    .W      (w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of one clock edge, from the counting rules in plain
  // integer arithmetic.
  task automatic model_edge();
    int se;
    int t;
    if (!rstn) begin
      mq = 0;
      mw = 0;
    end else if (l) begin
      mq = (int'(r) > MX) ? MX : int'(r);
      mw = 0;
    end else if (e) begin
      se = (int'(s) > MX) ? MX : int'(s);
      t  = ud ? mq + se : mq - se;
      if (t > MX || t < 0) begin
`ifdef BM_COUNTER_SATURATE_EN
        mq = (t > MX) ? MX : 0;
`else
        mq = (t > MX) ? t - (MX + 1) : t + (MX + 1);
`endif
        mw = 1;
      end else begin
        mq = t;
        mw = 0;
      end
    end else begin
      mw = 0;
    end
  endtask

  function automatic bit model_tc();
    return ud ? (mq == MX) : (mq == 0);
  endfunction

  // Advance one edge and leave time to settle before sampling.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic load(input int val);
    l = 1'b1; e = 1'b0; r = N'(val);
    tick();
    l = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; l = 1'b0; e = 1'b0; ud = 1'b0; r = '0; s = '0;
    #2;
    checks++;
    if (q !== 4'd0 || w !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: got Q=%0d W=%0b expected Q=0 W=0", q, w);
    end
    repeat (2) tick();
    rstn = 1'b1;
    load(6);
    e = 1'b1; ud = 1'b1; s = 4'd2;
    tick();
    // Drop reset between edges: outputs must clear without a clock.
    @(negedge clk);
    e = 1'b0; ud = 1'b0;
    rstn = 1'b0;
    #1;
    mq = 0; mw = 0;
    checks++;
    if (q !== 4'd0 || w !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got Q=%0d W=%0b expected Q=0 W=0", q, w);
    end
    checks++;
    if (tc !== 1'b1) begin
      errors++;
      $display("FAIL reset_tc_down: got %0b expected 1", tc);
    end
    ud = 1'b1;
    #1;
    checks++;
    if (tc !== 1'b0) begin
      errors++;
      $display("FAIL reset_tc_up: got %0b expected 0", tc);
    end
    tick();
    rstn = 1'b1;
    tick();
    checks++;
    if (q !== 4'd0 || w !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_hold: got Q=%0d W=%0b expected Q=0 W=0", q, w);
    end
  endtask

  task automatic test_load_clamp();
    load(13);
    checks++;
    if (q !== 4'd9 || w !== 1'b0) begin
      errors++;
      $display("FAIL load_clamp: got Q=%0d W=%0b expected Q=9 W=0", q, w);
    end
    l = 1'b1; e = 1'b1; ud = 1'b1; s = 4'd3; r = 4'd4;
    tick();
    l = 1'b0; e = 1'b0;
    checks++;
    if (q !== 4'd4 || w !== 1'b0) begin
      errors++;
      $display("FAIL load_wins: got Q=%0d W=%0b expected Q=4 W=0", q, w);
    end
  endtask

  task automatic test_up_wrap();
    int exp_q1, exp_q2;
    bit exp_w2;
`ifdef BM_COUNTER_SATURATE_EN
    exp_q1 = 9; exp_q2 = 9; exp_w2 = 1;
`else
    exp_q1 = 1; exp_q2 = 2; exp_w2 = 0;
`endif
    load(8);
    e = 1'b1; ud = 1'b1; s = 4'd3;
    tick();
    checks++;
    if (q !== N'(exp_q1) || w !== 1'b1) begin
      errors++;
      $display("FAIL up_wrap: got Q=%0d W=%0b expected Q=%0d W=1", q, w, exp_q1);
    end
    s = 4'd1;
    tick();
    e = 1'b0;
    checks++;
    if (q !== N'(exp_q2) || w !== exp_w2) begin
      errors++;
      $display("FAIL up_after_wrap: got Q=%0d W=%0b expected Q=%0d W=%0b", q, w, exp_q2, exp_w2);
    end
  endtask

  task automatic test_down_wrap();
    int exp_a, exp_b;
`ifdef BM_COUNTER_SATURATE_EN
    exp_a = 0; exp_b = 0;
`else
    exp_a = 8; exp_b = 6;
`endif
    load(1);
    e = 1'b1; ud = 1'b0; s = 4'd3;
    tick();
    e = 1'b0;
    checks++;
    if (q !== N'(exp_a) || w !== 1'b1) begin
      errors++;
      $display("FAIL down_wrap: got Q=%0d W=%0b expected Q=%0d W=1", q, w, exp_a);
    end
    load(5);
    e = 1'b1; ud = 1'b0; s = 4'd15;
    tick();
    e = 1'b0;
    checks++;
    if (q !== N'(exp_b) || w !== 1'b1) begin
      errors++;
      $display("FAIL down_wrap_clamped_step: got Q=%0d W=%0b expected Q=%0d W=1", q, w, exp_b);
    end
  endtask

  task automatic test_direction_change();
    load(9);
    ud = 1'b1;
    #1;
    checks++;
    if (tc !== 1'b1) begin
      errors++;
      $display("FAIL dir_tc_up: got %0b expected 1", tc);
    end
    ud = 1'b0;
    #1;
    checks++;
    if (tc !== 1'b0) begin
      errors++;
      $display("FAIL dir_tc_down: got %0b expected 0", tc);
    end
    e = 1'b1; s = 4'd1;
    tick();
    e = 1'b0;
    checks++;
    if (q !== 4'd8 || w !== 1'b0) begin
      errors++;
      $display("FAIL dir_no_lag: got Q=%0d W=%0b expected Q=8 W=0", q, w);
    end
  endtask

  task automatic test_limits();
    int exp_a;
`ifdef BM_COUNTER_SATURATE_EN
    exp_a = 0;
`else
    exp_a = 8;
`endif
    load(0);
    e = 1'b1; ud = 1'b0; s = 4'd2;
    tick();
    e = 1'b0;
    checks++;
    if (q !== N'(exp_a) || w !== 1'b1) begin
      errors++;
      $display("FAIL limit_down_from_zero: got Q=%0d W=%0b expected Q=%0d W=1", q, w, exp_a);
    end
    load(7);
    e = 1'b1; ud = 1'b1; s = 4'd2;
    tick();
    e = 1'b0;
    checks++;
    if (q !== 4'd9 || w !== 1'b0) begin
      errors++;
      $display("FAIL limit_exact_max: got Q=%0d W=%0b expected Q=9 W=0", q, w);
    end
    load(3);
    e = 1'b1; ud = 1'b0; s = 4'd3;
    tick();
    checks++;
    if (q !== 4'd0 || w !== 1'b0) begin
      errors++;
      $display("FAIL limit_exact_zero: got Q=%0d W=%0b expected Q=0 W=0", q, w);
    end
    s = 4'd0;
    tick();
    e = 1'b0;
    checks++;
    if (q !== 4'd0 || w !== 1'b0) begin
      errors++;
      $display("FAIL zero_step_hold: got Q=%0d W=%0b expected Q=0 W=0", q, w);
    end
  endtask

  task automatic test_back_to_back();
    load(9);
    e = 1'b1; ud = 1'b1; s = 4'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q !== N'(mq) || w !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back_%0d: got Q=%0d W=%0b expected Q=%0d W=1", i, q, w, mq);
      end
    end
    e = 1'b0;
    tick();
    checks++;
    if (w !== 1'b0 || q !== N'(mq)) begin
      errors++;
      $display("FAIL back_to_back_end: got Q=%0d W=%0b expected Q=%0d W=0", q, w, mq);
    end
  endtask

  task automatic test_reset_midcount();
    load(8);
    e = 1'b1; ud = 1'b1; s = 4'd5;
    rstn = 1'b0;
    #1;
    mq = 0; mw = 0;
    tick();
    checks++;
    if (q !== 4'd0 || w !== 1'b0) begin
      errors++;
      $display("FAIL reset_midcount: got Q=%0d W=%0b expected Q=0 W=0", q, w);
    end
    rstn = 1'b1; e = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      l  = ($urandom_range(0, 7) == 0);
      e  = ($urandom_range(0, 3) != 0);
      ud = 1'($urandom);
      r  = N'($urandom);
      s  = N'($urandom);
      #1;
      checks++;
      if (tc !== model_tc()) begin
        errors++;
        $display("FAIL rand_tc_%0d: got %0b expected %0b", i, tc, model_tc());
      end
      tick();
      checks++;
      if (q !== N'(mq) || w !== mw) begin
        errors++;
        $display("FAIL rand_step_%0d: got Q=%0d W=%0b expected Q=%0d W=%0b", i, q, w, mq, mw);
      end
    end
    l = 1'b0; e = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_clamp();
    test_up_wrap();
    test_down_wrap();
    test_direction_change();
    test_limits();
    test_back_to_back();
    test_reset_midcount();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
